// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INS_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {BOOT, REQ, WAIT, DROP} if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_buffer.sv
// Small FIFO of fetched {PC, instruction} pairs sitting between fetch and decode.
// Clear wins over push/pop; pointers wrap naturally since depth is a power of two.
module if_buffer
  import if_stage_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  fetch_entry_t     mem_q [BUF_DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL) || do_pop);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (clear_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (do_push) wr_d = wr_q + AW'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage is data only; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches over a valid/ready memory port and
// buffers instructions for decode. Optional perf counters under `IF_PERF_CNT_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            Stall,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectPC,
  output logic            IMReq,
  output logic [XLEN-1:0] IMAddr,
  input  logic            IMReady,
  input  logic            IMRValid,
  input  logic [XLEN-1:0] IMRData,
  output logic [XLEN-1:0] IFPC,
  output logic [XLEN-1:0] INS,
  output logic            IFValid,
  output logic            Flush
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     FetchCnt,
  output logic [31:0]     RedirCnt
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0] OCC_ONE   = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] OCC_LIMIT = (CNT_W+1)'(BUF_DEPTH);

  if_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic             push, pop, clear, fire, valid, slot_ok;
  logic [CNT_W:0]   occ;

  assign valid = (count != '0);
  assign pop   = valid && !Stall && !Redirect;

  // Occupancy if one more request were issued now; its response needs a slot.
  assign occ     = {1'b0, count} - {{CNT_W{1'b0}}, pop} + OCC_ONE;
  assign slot_ok = (occ < OCC_LIMIT);

  assign push_data = '{pc: req_pc_q, ins: IMRData};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    IMReq    = 1'b0;
    push     = 1'b0;
    clear    = 1'b0;
    fire     = 1'b0;

    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        IMReq = slot_ok;
        fire  = IMReq && IMReady;
        if (fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        IMReq = IMRValid && slot_ok;
        fire  = IMReq && IMReady;
        if (IMRValid) begin
          push = 1'b1;
          if (fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
          end else begin
            state_d = REQ;
          end
        end
      end
      DROP: if (IMRValid) state_d = REQ;
      default: state_d = BOOT;
    endcase

    // A redirect flushes everything; a response still in flight must be swallowed.
    if (Redirect) begin
      IMReq    = 1'b0;
      fire     = 1'b0;
      push     = 1'b0;
      clear    = 1'b1;
      pc_d     = word_align(RedirectPC);
      req_pc_d = req_pc_q;
      if ((state_q == WAIT || state_q == DROP) && !IMRValid) state_d = DROP;
      else                                                   state_d = REQ;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= word_align(RESET_PC);
      req_pc_q <= word_align(RESET_PC);
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  if_buffer #(
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (CNT_W)
  ) u_buf (
    .clk_i       (CLK),
    .rst_i       (rst),
    .clear_i     (clear),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  assign IMAddr  = pc_q;
  assign IFValid = valid;
  assign Flush   = !valid;
  assign IFPC    = valid ? head.pc  : '0;
  assign INS     = valid ? head.ins : INS_NOP;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, redir_cnt_q;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (push)     fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (Redirect) redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign FetchCnt = fetch_cnt_q;
  assign RedirCnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: memory model plus PC/instruction scoreboard.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        Stall = 1'b0, Redirect = 1'b0, IMReady = 1'b1, IMRValid = 1'b0;
  logic [31:0] RedirectPC = '0, IMRData = '0;
  logic        IMReq, IFValid, Flush;
  logic [31:0] IMAddr, IFPC, INS;
`ifdef IF_PERF_CNT_EN
  logic [31:0] FetchCnt, RedirCnt;
`endif

  if_stage #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .CLK(CLK), .rst(rst), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .IMReq(IMReq), .IMAddr(IMAddr), .IMReady(IMReady), .IMRValid(IMRValid),
    .IMRData(IMRData), .IFPC(IFPC), .INS(INS), .IFValid(IFValid), .Flush(Flush)
`ifdef IF_PERF_CNT_EN
    , .FetchCnt(FetchCnt), .RedirCnt(RedirCnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
  endfunction

  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} exp_t;
  exp_t        sb[$];
  logic [31:0] popped[$];

  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          lat = 1;
  logic [31:0] exp_addr = '0;
  int          fire_cnt = 0;
  logic [31:0] last_fire_addr = '0;
  logic        s_req, s_vld, s_flush;
  logic [31:0] s_addr, s_pc, s_ins;

  // One clock: drive at negedge, evaluate settled values, return at next negedge.
  task automatic cycle(input logic stall, input logic redir, input logic [31:0] rpc, input logic rdy);
    logic fire;
    exp_t e;
    Stall = stall; Redirect = redir; RedirectPC = rpc; IMReady = rdy;
    IMRValid = mem_pend && (mem_cnt == 1);
    IMRData  = IMRValid ? memf(mem_addr) : 32'hDEAD_BEEF;
    #1;
    s_req = IMReq; s_addr = IMAddr; s_vld = IFValid; s_pc = IFPC; s_ins = INS; s_flush = Flush;
    check_eq("flush_vs_valid", {31'd0, Flush}, {31'd0, !IFValid});
    fire = IMReq && IMReady;
    if (redir) begin
      check_eq("redirect_no_req", {31'd0, IMReq}, 32'd0);
      sb.delete();
      exp_addr = rpc & ~32'h3;
    end else begin
      if (IFValid && !stall) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_valid", {31'd0, IFValid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("ifpc", IFPC, e.pc);
          check_eq("ins", INS, e.ins);
        end
        popped.push_back(IFPC);
      end
      if (fire) begin
        check_eq("imaddr", IMAddr, exp_addr);
        sb.push_back('{pc: IMAddr, ins: memf(IMAddr)});
        exp_addr = exp_addr + 32'd4;
      end
    end
    if (IMRValid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (fire) begin
      check_eq("one_outstanding", {31'd0, mem_pend}, 32'd0);
      mem_pend = 1'b1; mem_cnt = lat; mem_addr = IMAddr;
      fire_cnt++; last_fire_addr = IMAddr;
    end
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic run_until_pend(input int want, input string tag);
    int n = 0;
    while (!(mem_pend && mem_cnt == want) && n < 50) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end
    check_eq(tag, {31'd0, (mem_pend && mem_cnt == want)}, 32'd1);
  endtask

  task automatic run_until_fire(input logic [31:0] want, input string tag);
    int fc = fire_cnt;
    int n = 0;
    while (fire_cnt == fc && n < 30) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end
    check_eq(tag, last_fire_addr, want);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_imreq"}, {31'd0, IMReq}, 32'd0);
    check_eq({tag, "_imaddr"}, IMAddr, 32'h0);
    check_eq({tag, "_ifvalid"}, {31'd0, IFValid}, 32'd0);
    check_eq({tag, "_ifpc"}, IFPC, 32'h0);
    check_eq({tag, "_ins"}, INS, 32'h0000_0013);
    check_eq({tag, "_flush"}, {31'd0, Flush}, 32'd1);
`ifdef IF_PERF_CNT_EN
    check_eq({tag, "_fetchcnt"}, FetchCnt, 32'd0);
    check_eq({tag, "_redircnt"}, RedirCnt, 32'd0);
`endif
  endtask

  task automatic startup(input string tag);
    int first = -1;
    int base  = popped.size();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (s_vld && first < 0) first = k;
    end
    check_eq({tag, "_first_valid_cycle"}, first, 3);
    check_eq({tag, "_first_pc"}, (popped.size() > base) ? popped[base] : 32'hFFFF_FFFF, 32'h0);
    check_eq({tag, "_second_pc"}, (popped.size() > base + 1) ? popped[base+1] : 32'hFFFF_FFFF, 32'h4);
  endtask

  initial begin
    int base;
    int fc;
    logic [31:0] a1;

    // Reset values while rst is held.
    @(negedge CLK);
    #1;
    check_reset_vals("reset");
    @(negedge CLK);
    rst = 1'b0;
    startup("boot");

    // Decode stall while PC 8 is presented.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_eq("stall_vld", {31'd0, s_vld}, 32'd1);
      check_eq("stall_pc", s_pc, 32'h8);
      check_eq("stall_ins", s_ins, memf(32'h8));
      if (i >= 1) check_eq("stall_full_noreq", {31'd0, s_req}, 32'd0);
    end
    base = popped.size();
    run(8);
    check_eq("resume_pc0", (popped.size() > base) ? popped[base] : 32'hFFFF_FFFF, 32'h8);
    check_eq("resume_pc1", (popped.size() > base + 1) ? popped[base+1] : 32'hFFFF_FFFF, 32'hC);
    check_eq("resume_pc2", (popped.size() > base + 2) ? popped[base+2] : 32'hFFFF_FFFF, 32'h10);

    // Redirect while waiting; the late response must be dropped.
    lat = 2;
    run_until_pend(2, "reach_wait_lat2");
    cycle(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("redir_wait_empty", {31'd0, s_vld}, 32'd0);
    check_eq("redir_wait_flush", {31'd0, s_flush}, 32'd1);
    run_until_fire(32'h100, "redir_wait_next_addr");
    base = popped.size();
    run(8);
    check_eq("redir_wait_first_pc", (popped.size() > base) ? popped[base] : 32'hFFFF_FFFF, 32'h100);

    // Redirect in the same cycle as a response.
    lat = 1;
    run_until_pend(1, "reach_rsp_cycle");
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("redir_rsp_empty", {31'd0, s_vld}, 32'd0);
    check_eq("redir_rsp_flush", {31'd0, s_flush}, 32'd1);
    check_eq("redir_rsp_next_addr", last_fire_addr, 32'h200);
    run(5);

    // Memory not ready for 4 cycles.
    fc = fire_cnt;
    a1 = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      if (i == 1) a1 = s_addr;
      if (i >= 1) check_eq("notready_req", {31'd0, s_req}, 32'd1);
      if (i >= 2) check_eq("notready_addr", s_addr, a1);
      if (i == 3) check_eq("notready_drained", {31'd0, s_flush}, 32'd1);
    end
    check_eq("notready_nofire", fire_cnt - fc, 0);
    run(6);

    // Asynchronous reset in the middle of a fetch.
    lat = 2;
    run_until_pend(2, "reach_wait_rst");
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    sb.delete();
    mem_pend = 1'b0;
    exp_addr = 32'h0;
    lat = 1;
    IMRValid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    startup("restart");
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage directly upstream of decode. Owns the PC and issues requests to instruction memory over a valid/ready interface.
- Buffers returned instructions and presents {IFPC, INS} to decode, with Flush asserted on bubbles.
- Accepts redirects from the branch/jump resolution path (DEBranchFlush with target BJumpRSIMM) and holds its output under a decode stall.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, instruction buffer entries; power of 2, >=2.

Ports:
- CLK  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Stall  in  1  decode cannot accept this cycle; hold head.
- Redirect  in  1  control-flow change (DEBranchFlush).
- RedirectPC  in  32  new fetch address (BJumpRSIMM).
- IMReq  out  1  instruction memory request valid.
- IMAddr  out  32  request address, word aligned.
- IMReady  in  1  memory accepts request.
- IMRValid  in  1  response valid; always accepted, in order, >=1 cycle after handshake.
- IMRData  in  32  response instruction word.
- IFPC  out  32  PC of presented instruction.
- INS  out  32  presented instruction.
- IFValid  out  1  IFPC/INS valid.
- Flush  out  1  bubble to decode; equals ~IFValid.

Behaviour:
- Reset values: IMReq=0, IMAddr=RESET_PC, IFValid=0, IFPC=0, INS=32'h0000_0013 (NOP), Flush=1, buffer empty, state=BOOT, PC=RESET_PC.
- Handshake: request fires when IMReq&IMReady. At most one request is outstanding. IMAddr and IMReq hold stable until fired. IMAddr[1:0] is always 00; RedirectPC[1:0] is ignored.
- Slot rule: a request may be issued only if (count − pop + inflight_after) < BUF_DEPTH. inflight_after is 1 if a request stays outstanding after this cycle.
- FSM:
  - BOOT: one cycle after reset release, IMReq=0 → REQ.
  - REQ: IMReq=slot_ok. On fire: ReqPC<=PC, PC<=PC+4 (mod 2^32, wraps) → WAIT.
  - WAIT: IMReq=IMRValid&slot_ok (combinational path allowed; gives back-to-back 1 instr/cycle at latency 1). On IMRValid: push {ReqPC, IMRData}. If a new request fires the same cycle, stay WAIT with ReqPC<=PC, PC<=PC+4; otherwise → REQ.
  - DROP: IMReq=0. On IMRValid: discard → REQ.
- Redirect (priority over everything, any state):
  - Buffer cleared, PC<=RedirectPC, IMReq forced 0 that cycle, no push.
  - WAIT with IMRValid the same cycle: response discarded → REQ.
  - WAIT without IMRValid: → DROP.
  - DROP: stays DROP, PC updated.
  - REQ/BOOT: → REQ.
  - Next fetch address is RedirectPC; first new instruction reaches IFValid no earlier than 2 cycles after redirect.
- Output:
  - Head of buffer drives IFPC/INS; IFValid=(count!=0).
  - When empty: INS=NOP, IFPC=0.
  - Pop when IFValid & ~Stall & ~Redirect. Stall holds IFPC/INS/IFValid unchanged. Push and pop in the same cycle keeps count.
- Full buffer: no new requests; the outstanding response always has a reserved slot, so no overflow is possible.
- Reset mid-operation: immediate return to reset values; any late response is ignored because the FSM is in BOOT/REQ with nothing outstanding.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs FetchCnt[31:0] (increments per push) and RedirCnt[31:0] (increments per Redirect cycle). Both reset to 0, wrap at 2^32, and are not cleared by Redirect.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - FSM state enum {BOOT, REQ, WAIT, DROP}.
  - INS_NOP=32'h0000_0013.
  - PC_STEP=4.
  - XLEN=32.
- One sub-module: if_buffer, a synchronous FIFO of {PC, INS}, BUF_DEPTH entries, with push/pop/clear, count, and head outputs.

Test Plan:
- Reset, memory ready always, latency 1 → IFValid first high on cycle 3 after release with IFPC=0; then 4, 8, 12 on consecutive cycles, INS matching memory.
- Stall high 3 cycles while IFPC=8 → IFPC/INS held; IMReq stops once buffer full (count=2 plus none outstanding); resumes 12, 16 after release.
- Redirect to 0x100 while in WAIT, response arrives 2 cycles later → that response is dropped; next IMAddr=0x100; IFPC=0x100 appears, stale PC never presented.
- Redirect to 0x200 in the same cycle as IMRValid → data discarded, buffer empty, Flush=1, next IMAddr=0x200.
- IMReady low 4 cycles → IMReq held high with IMAddr stable; no PC advance; Flush=1 once the buffer drains.
- Async rst asserted mid-WAIT → outputs return to reset values the same cycle; fetch restarts at RESET_PC. With IF_PERF_CNT_EN, FetchCnt=0 after rst.
